// File: rtl/bcd_down_counter_scan.sv
// rtl/bcd_down_counter_scan.sv - 4-digit BCD down counter with leading-zero blanking and display scan index
module bcd_down_counter_scan #(
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 100000,
  parameter bit WRAP     = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LOAD,
  input  logic [15:0] LOAD_VALUE,
  input  logic        ENABLE,
  output logic [4:0]  DIGIT0,
  output logic [4:0]  DIGIT1,
  output logic [4:0]  DIGIT2,
  output logic [4:0]  DIGIT3,
  output logic [1:0]  SEG_SEL,
  output logic        ZERO,
  output logic        RUNNING
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXPIRED} state_t;

  state_t            state_q, state_d;
  logic [3:0][3:0]   count_q, count_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]     scan_cnt_q;
  logic [1:0]        seg_sel_q;
  logic              zero_q;
  logic              tick;
  logic [3:0][3:0]   load_val;
  logic              load_is_zero;

  function automatic logic [3:0][3:0] bcd_clamp(input logic [3:0][3:0] v);
    logic [3:0][3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (v[i] > 4'd9) ? 4'd9 : v[i];
    return r;
  endfunction

  // Ripple borrow: 0000 naturally becomes 9999, which is the wrap value.
  function automatic logic [3:0][3:0] bcd_dec(input logic [3:0][3:0] c);
    logic [3:0][3:0] r;
    logic            borrow;
    r      = c;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (c[i] == 4'd0) begin
          r[i] = 4'd9;
        end else begin
          r[i]   = c[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick         = (state_q == S_RUN) && ENABLE && (tick_cnt_q == TICK_LAST);
  assign load_val     = bcd_clamp(LOAD_VALUE);
  assign load_is_zero = (load_val == '0);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tick_cnt_d = tick_cnt_q;
    if (LOAD) begin
      count_d    = load_val;
      tick_cnt_d = '0;
      if (ENABLE && !load_is_zero)      state_d = S_RUN;
      else if (ENABLE && !WRAP)         state_d = S_EXPIRED;
      else                              state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ENABLE) begin
            if (count_q != '0)          state_d = S_RUN;
            else if (!WRAP)             state_d = S_EXPIRED;
          end
        end
        S_RUN: begin
          if (!ENABLE) begin
            state_d = S_IDLE;
          end else if (tick) begin
            tick_cnt_d = '0;
            if (!WRAP && count_q == 16'h0001) begin
              count_d = '0;
              state_d = S_EXPIRED;
            end else if (WRAP || count_q != '0) begin
              count_d = bcd_dec(count_q);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_EXPIRED: state_d = S_EXPIRED;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      tick_cnt_q <= '0;
      zero_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tick_cnt_q <= tick_cnt_d;
      zero_q     <= (count_d == '0);
    end
  end

  // Scan index free-runs in every state; only RESET restarts it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_cnt_q <= '0;
      seg_sel_q  <= 2'd0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      seg_sel_q  <= seg_sel_q + 2'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + SW'(1);
    end
  end

  logic blank3, blank2, blank1;
  assign blank3 = (count_q[3] == 4'd0);
  assign blank2 = blank3 && (count_q[2] == 4'd0);
  assign blank1 = blank2 && (count_q[1] == 4'd0);

  assign DIGIT0  = {1'b0,   count_q[0]};
  assign DIGIT1  = {blank1, count_q[1]};
  assign DIGIT2  = {blank2, count_q[2]};
  assign DIGIT3  = {blank3, count_q[3]};
  assign SEG_SEL = seg_sel_q;
  assign ZERO    = zero_q;
  assign RUNNING = (state_q == S_RUN);

endmodule

// File: tb/tb_bcd_down_counter_scan.sv
// tb/tb_bcd_down_counter_scan.sv - directed bench for bcd_down_counter_scan (WRAP=0 and WRAP=1 instances)
module tb_bcd_down_counter_scan;

  logic        clk = 1'b0;
  logic        reset, load, enable;
  logic [15:0] load_value;

  logic [4:0] d0, d1, d2, d3, w0, w1, w2, w3;
  logic [1:0] seg_sel, w_seg_sel;
  logic       zero, running, w_zero, w_running;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_down_counter_scan #(.TICK_DIV(4), .SCAN_DIV(2), .WRAP(1'b0)) dut (
    .CLK(clk), .RESET(reset), .LOAD(load), .LOAD_VALUE(load_value), .ENABLE(enable),
    .DIGIT0(d0), .DIGIT1(d1), .DIGIT2(d2), .DIGIT3(d3),
    .SEG_SEL(seg_sel), .ZERO(zero), .RUNNING(running)
  );

  bcd_down_counter_scan #(.TICK_DIV(4), .SCAN_DIV(2), .WRAP(1'b1)) dut_w (
    .CLK(clk), .RESET(reset), .LOAD(load), .LOAD_VALUE(load_value), .ENABLE(enable),
    .DIGIT0(w0), .DIGIT1(w1), .DIGIT2(w2), .DIGIT3(w3),
    .SEG_SEL(w_seg_sel), .ZERO(w_zero), .RUNNING(w_running)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] cnt();
    return {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
  endfunction

  function automatic logic [15:0] cnt_w();
    return {w3[3:0], w2[3:0], w1[3:0], w0[3:0]};
  endfunction

  task automatic do_load(input logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    step(1);
    load       = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; enable = 1'b0; load_value = 16'h0000;
    step(3);
    check("rst_zero",    32'(zero),    32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_seg",     32'(seg_sel), 32'd0);
    check("rst_digits",  {12'd0, d3, d2, d1, d0}, {12'd0, 5'b10000, 5'b10000, 5'b10000, 5'b00000});
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(2);
      check($sformatf("seg_step%0d", i), 32'(seg_sel), 32'(i % 4));
    end

    // Borrow chain
    enable = 1'b1;
    do_load(16'h1000);
    check("brw_loaded",  32'(cnt()),   32'h1000);
    check("brw_running", 32'(running), 32'd1);
    step(3);
    check("brw_hold",    32'(cnt()),   32'h1000);
    step(1);
    check("brw_0999",    32'(cnt()),   32'h0999);
    check("brw_d3blank", 32'(d3),      32'h10);
    check("brw_d2",      32'(d2),      32'h09);
    step(4);
    check("brw_0998",    32'(cnt()),   32'h0998);

    // Terminal count; the WRAP=1 instance runs the same stimulus
    do_load(16'h0002);
    step(4);
    check("term_0001",   32'(cnt()),   32'h0001);
    step(4);
    check("term_0000",   32'(cnt()),   32'h0000);
    check("term_zero",   32'(zero),    32'd1);
    check("term_expired",32'(running), 32'd0);
    check("wrap_0000",   32'(cnt_w()), 32'h0000);
    check("wrap_zero",   32'(w_zero),  32'd1);
    check("wrap_run0",   32'(w_running), 32'd1);
    step(4);
    check("wrap_9999",   32'(cnt_w()), 32'h9999);
    check("wrap_run1",   32'(w_running), 32'd1);
    check("wrap_noblank",{12'd0, w3, w2, w1, w0}, {12'd0, 5'h09, 5'h09, 5'h09, 5'h09});
    check("wrap_nzero",  32'(w_zero),  32'd0);
    step(4);
    check("term_stay",   32'(cnt()),   32'h0000);
    check("term_stay_run", 32'(running), 32'd0);
    check("term_blank",  {12'd0, d3, d2, d1, d0}, {12'd0, 5'b10000, 5'b10000, 5'b10000, 5'b00000});
    do_load(16'h0005);
    check("exp_reload_run", 32'(running), 32'd1);
    check("exp_reload",  32'(cnt()),   32'h0005);
    step(4);
    check("exp_0004",    32'(cnt()),   32'h0004);

    // LOAD on the exact tick cycle
    step(3);
    check("lt_pre",      32'(cnt()),   32'h0004);
    do_load(16'h0300);
    check("lt_loaded",   32'(cnt()),   32'h0300);
    step(3);
    check("lt_hold",     32'(cnt()),   32'h0300);
    step(1);
    check("lt_0299",     32'(cnt()),   32'h0299);

    // Pause mid-prescale (two counts already elapsed)
    step(2);
    enable = 1'b0;
    step(10);
    check("pause_cnt",   32'(cnt()),   32'h0299);
    check("pause_idle",  32'(running), 32'd0);
    enable = 1'b1;
    step(1);
    check("resume_run",  32'(running), 32'd1);
    step(1);
    check("resume_hold", 32'(cnt()),   32'h0299);
    step(1);
    check("resume_0298", 32'(cnt()),   32'h0298);

    // Clamp and reset overriding LOAD
    do_load(16'hA5F3);
    check("clamp_9593",  32'(cnt()),   32'h9593);
    check("clamp_d3",    32'(d3),      32'h09);
    step(1);
    reset = 1'b1; load = 1'b1; load_value = 16'h1234;
    step(1);
    check("rrst_zero",   32'(zero),    32'd1);
    check("rrst_running",32'(running), 32'd0);
    check("rrst_seg",    32'(seg_sel), 32'd0);
    check("rrst_digits", {12'd0, d3, d2, d1, d0}, {12'd0, 5'b10000, 5'b10000, 5'b10000, 5'b00000});
    reset = 1'b0; load = 1'b0;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
